pet_stat_engine: RTL and testbench
==================================

// Module: pet_stat_engine
// PURPOSE
//  Parametrised successor to the fixed four-stat pet logic (hunger/happiness/clean/health).
//  Holds NUM_STATS saturating stat channels that decay on a prescaled tick, rise on accepted
//  actions from the menu controller, and raise per-channel alarms at zero. Sits between the
//  menu/exec logic and the display/status outputs of top_system.
// PARAMETERS
//  NUM_STATS      4    number of stat channels (1..16)
//  SEL_W          2    width of act_sel / cfg_idx; 2**SEL_W >= NUM_STATS
//  STAT_W         8    width of each stat value
//  STAT_MAX       10   saturation ceiling of every stat (< 2**STAT_W)
//  RESET_VAL      5    stat value after reset
//  ACTION_GAIN    1    increment applied per accepted action
//  TICK_DIV       50   clk cycles per decay tick (>= 1)
//  PER_W          16   width of decay period registers
//  DEFAULT_PERIOD 60   decay period (ticks) after reset; 0 = decay disabled
//  COOLDOWN       8    clk cycles act_ready stays low after an accepted action (0 = none)
// PORTS
//  clk          in   1                  system clock
//  rst          in   1                  synchronous reset, active-high
//  act_valid    in   1                  action request
//  act_sel      in   SEL_W              target channel of action
//  act_ready    out  1                  engine can accept an action this cycle
//  act_err      out  1                  1-cycle pulse: accepted action had act_sel >= NUM_STATS
//  cfg_we       in   1                  decay period write strobe
//  cfg_idx      in   SEL_W              channel for cfg write
//  cfg_period   in   PER_W              new decay period (ticks)
//  stats        out  NUM_STATS*STAT_W   stat values, channel i at [i*STAT_W +: STAT_W]
//  alarm        out  NUM_STATS          level: channel stat == 0
//  any_alarm    out  1                  OR of alarm
//  zero_evt     out  NUM_STATS          1-cycle pulse when channel goes nonzero -> 0
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): all stats = RESET_VAL, periods = DEFAULT_PERIOD, prescaler
//   and decay counters = 0, act_ready = 1, act_err = 0, zero_evt = 0, alarm = 0 (RESET_VAL>0).
//   Reset overrides every other input in that cycle, incl. mid-cooldown or mid-cfg.
//  Prescaler: counts 0..TICK_DIV-1, wraps; tick = 1 on the cycle count == TICK_DIV-1.
//  Decay, per channel i, on tick: if period[i]==0 nothing; else if dcnt[i]==period[i]-1 then
//   dcnt[i]<=0 and stat[i] <= (stat[i]==0) ? 0 : stat[i]-1; else dcnt[i]++.
//  Action handshake: accepted when act_valid & act_ready at posedge. If act_sel < NUM_STATS:
//   stat[sel] <= min(stat[sel]+ACTION_GAIN, STAT_MAX) (compute in STAT_W+1 bits), dcnt[sel]<=0.
//   Else no stat change, act_err pulses next cycle. Either way act_ready drops the following
//   cycle for COOLDOWN cycles, then returns to 1. act_valid while act_ready=0 is ignored.
//  Same-cycle action and decay on the same channel: action wins, decay step suppressed,
//   dcnt cleared. Decay on other channels proceeds normally.
//  Cfg write: cfg_we with cfg_idx < NUM_STATS sets period[idx]<=cfg_period and dcnt[idx]<=0
//   (wins over same-cycle decay count for that channel); cfg_idx out of range ignored.
//   Cfg and action may occur the same cycle; both applied.
//  Outputs registered; stats/alarm/any_alarm reflect state after the edge (0-cycle view of
//   registers). zero_evt[i] asserts the cycle after stat[i] becomes 0 from nonzero.
//  Stats never exceed STAT_MAX nor underflow below 0.
// TESTING (TICK_DIV=4, DEFAULT_PERIOD=3, COOLDOWN=2, defaults otherwise)
//  Reset: rst=1 two cycles -> stats all 5, alarm=0, act_ready=1; hold rst 30 cycles -> no decay.
//  Decay: idle from reset -> each stat drops by 1 every 12 cycles; reaches 0 after 60 cycles,
//   zero_evt pulses once per channel, alarm=4'hF, stays 0 afterwards (no underflow).
//  Action: act_sel=1 pulse -> stat1 5->6, act_ready low 2 cycles; 10 back-to-back requests
//   -> only every third accepted, stat1 saturates at 10.
//  Collision: action on ch0 in the tick that would decay it -> stat0 +1 only, next decay 12
//   cycles later; act_sel=3'b... out of range (NUM_STATS=3 build) -> act_err pulse, no change.
//  Config: cfg_we idx=2 period=0 -> stat2 frozen 200 cycles; period=1 -> drops every 4 cycles.
//  Reset mid-op: assert rst during cooldown and mid-decay -> all state back to reset values.

Source files
------------

// File: rtl/pet_stat_engine.sv
// pet_stat_engine: saturating pet stat channels with prescaled decay, action handshake and zero alarms
module pet_stat_engine #(
    parameter int NUM_STATS      = 4,
    parameter int SEL_W          = 2,
    parameter int STAT_W         = 8,
    parameter int STAT_MAX       = 10,
    parameter int RESET_VAL      = 5,
    parameter int ACTION_GAIN    = 1,
    parameter int TICK_DIV       = 50,
    parameter int PER_W          = 16,
    parameter int DEFAULT_PERIOD = 60,
    parameter int COOLDOWN       = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        act_valid,
    input  logic [SEL_W-1:0]            act_sel,
    output logic                        act_ready,
    output logic                        act_err,
    input  logic                        cfg_we,
    input  logic [SEL_W-1:0]            cfg_idx,
    input  logic [PER_W-1:0]            cfg_period,
    output logic [NUM_STATS*STAT_W-1:0] stats,
    output logic [NUM_STATS-1:0]        alarm,
    output logic                        any_alarm,
    output logic [NUM_STATS-1:0]        zero_evt
);
    localparam int ps_w = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int cd_w = COOLDOWN > 1 ? $clog2(COOLDOWN) : 1;
    localparam logic [ps_w-1:0]   ps_last = ps_w'(TICK_DIV - 1);
    localparam logic [ps_w-1:0]   ps_one  = ps_w'(1);
    localparam logic [cd_w-1:0]   cd_load = cd_w'(COOLDOWN > 0 ? COOLDOWN - 1 : 0);
    localparam logic [cd_w-1:0]   cd_one  = cd_w'(1);
    localparam logic [STAT_W:0]   sum_max = (STAT_W+1)'(STAT_MAX);
    localparam logic [STAT_W:0]   gain    = (STAT_W+1)'(ACTION_GAIN);
    localparam logic [STAT_W-1:0] s_max   = STAT_W'(STAT_MAX);
    localparam logic [STAT_W-1:0] s_rst   = STAT_W'(RESET_VAL);
    localparam logic [STAT_W-1:0] s_one   = STAT_W'(1);
    localparam logic [PER_W-1:0]  p_def   = PER_W'(DEFAULT_PERIOD);
    localparam logic [PER_W-1:0]  p_one   = PER_W'(1);

    logic [ps_w-1:0]      ps;
    logic [cd_w-1:0]      cd;
    logic [STAT_W-1:0]    stat [NUM_STATS];
    logic [STAT_W-1:0]    stat_n [NUM_STATS];
    logic [PER_W-1:0]     period [NUM_STATS];
    logic [PER_W-1:0]     period_n [NUM_STATS];
    logic [PER_W-1:0]     dcnt [NUM_STATS];
    logic [PER_W-1:0]     dcnt_n [NUM_STATS];
    logic [STAT_W:0]      sum [NUM_STATS];
    logic [NUM_STATS-1:0] act_hit, cfg_hit, dec_hit, live, zero_n;
    logic                 tick, acc, sel_ok;

    assign tick   = ps == ps_last;
    assign acc    = act_valid & act_ready;
    assign sel_ok = 32'(act_sel) < NUM_STATS;

    for (genvar g = 0; g < NUM_STATS; g++) begin : g_out
        assign stats[g*STAT_W +: STAT_W] = stat[g];
    end

    // per-channel next state: action beats decay, cfg and action both restart the decay count
    always_comb begin
        act_hit  = '0;
        cfg_hit  = '0;
        dec_hit  = '0;
        live     = '0;
        zero_n   = '0;
        sum      = '{default: '0};
        stat_n   = stat;
        period_n = period;
        dcnt_n   = dcnt;
        for (int i = 0; i < NUM_STATS; i++) begin
            act_hit[i]  = acc && sel_ok && act_sel == SEL_W'(i);
            cfg_hit[i]  = cfg_we && cfg_idx == SEL_W'(i);
            live[i]     = tick && period[i] != '0;
            dec_hit[i]  = live[i] && dcnt[i] == period[i] - p_one;
            sum[i]      = {1'b0, stat[i]} + gain;
            stat_n[i]   = act_hit[i] ? (sum[i] > sum_max ? s_max : sum[i][STAT_W-1:0]) :
                          (dec_hit[i] && stat[i] != '0) ? stat[i] - s_one : stat[i];
            period_n[i] = cfg_hit[i] ? cfg_period : period[i];
            dcnt_n[i]   = (act_hit[i] || cfg_hit[i] || dec_hit[i]) ? '0 :
                          live[i] ? dcnt[i] + p_one : dcnt[i];
            zero_n[i]   = stat_n[i] == '0;
        end
    end

    // state and registered outputs; cooldown counter holds act_ready low after each accept
    always_ff @(posedge clk) begin
        if (rst) begin
            ps        <= '0;
            cd        <= '0;
            act_ready <= 1'b1;
            act_err   <= 1'b0;
            alarm     <= {NUM_STATS{RESET_VAL == 0}};
            any_alarm <= RESET_VAL == 0;
            zero_evt  <= '0;
            for (int i = 0; i < NUM_STATS; i++) begin
                stat[i]   <= s_rst;
                period[i] <= p_def;
                dcnt[i]   <= '0;
            end
        end else begin
            ps        <= tick ? '0 : ps + ps_one;
            cd        <= acc ? cd_load : (cd != '0 ? cd - cd_one : cd);
            act_ready <= acc ? (COOLDOWN == 0) : (act_ready | (cd == '0));
            act_err   <= acc && !sel_ok;
            alarm     <= zero_n;
            any_alarm <= |zero_n;
            zero_evt  <= zero_n & ~alarm;
            stat      <= stat_n;
            period    <= period_n;
            dcnt      <= dcnt_n;
        end
    end
endmodule

// File: tb/tb_pet_stat_engine.sv
// tb_pet_stat_engine: vector table, corner sequences and random run against a rule-level model
module tb_pet_stat_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        act_valid = 1'b0;
    logic [2:0]  act_sel = '0;
    logic        act_ready, act_err;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [15:0] cfg_period = '0;
    logic [31:0] stats;
    logic [3:0]  alarm, zero_evt;
    logic        any_alarm;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pet_stat_engine #(
        .NUM_STATS(4), .SEL_W(3), .STAT_W(8), .STAT_MAX(10), .RESET_VAL(5), .ACTION_GAIN(1),
        .TICK_DIV(4), .PER_W(16), .DEFAULT_PERIOD(3), .COOLDOWN(2)
    ) dut (
        .clk(clk), .rst(rst), .act_valid(act_valid), .act_sel(act_sel), .act_ready(act_ready),
        .act_err(act_err), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_period(cfg_period),
        .stats(stats), .alarm(alarm), .any_alarm(any_alarm), .zero_evt(zero_evt)
    );

    // reference model: edge index since reset, ticks seen per channel, ready-from edge
    int m_stat [4];
    int m_per [4];
    int m_tc [4];
    int m_pc = 0;
    int e = 0;
    int m_rdy_from = 0;
    bit m_err = 0;
    bit [3:0] m_zev = '0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", nm, e, got, exp);
        end
    endtask

    task automatic model();
        bit tick, acc;
        int ch, prev;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_stat[i] = 5;
                m_per[i] = 3;
                m_tc[i] = 0;
            end
            m_zev = '0;
            m_pc = 0;
            e = 0;
            m_rdy_from = 0;
            m_err = 0;
        end else begin
            tick = m_pc == 3;
            m_pc = (m_pc + 1) % 4;
            acc = act_valid && e >= m_rdy_from;
            e++;
            if (acc) m_rdy_from = e + 2;
            m_err = acc && act_sel >= 4;
            ch = (acc && act_sel < 4) ? int'(act_sel) : -1;
            for (int i = 0; i < 4; i++) begin
                prev = m_stat[i];
                if (i == ch) begin
                    m_stat[i] = (m_stat[i] + 1 > 10) ? 10 : m_stat[i] + 1;
                    m_tc[i] = 0;
                end else if (tick && m_per[i] > 0) begin
                    m_tc[i]++;
                    if (m_tc[i] == m_per[i]) begin
                        m_tc[i] = 0;
                        if (m_stat[i] > 0) m_stat[i]--;
                    end
                end
                m_zev[i] = prev != 0 && m_stat[i] == 0;
            end
            if (cfg_we && cfg_idx < 4) begin
                m_per[cfg_idx] = int'(cfg_period);
                m_tc[cfg_idx] = 0;
            end
        end
    endtask

    task automatic cyc();
        logic [31:0] xs;
        logic [3:0] xa;
        @(posedge clk);
        model();
        #1;
        for (int i = 0; i < 4; i++) begin
            xs[8*i +: 8] = 8'(m_stat[i]);
            xa[i] = m_stat[i] == 0;
        end
        chk("model_stats", stats, xs);
        chk("model_alarm", alarm, xa);
        chk("model_any_alarm", any_alarm, |xa);
        chk("model_zero_evt", zero_evt, m_zev);
        chk("model_ready", act_ready, e >= m_rdy_from);
        chk("model_err", act_err, m_err);
    endtask

    task automatic idle(input int n);
        act_valid = 1'b0;
        cfg_we = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        act_valid = 1'b0;
        cfg_we = 1'b0;
        repeat (n) cyc();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        av;
        logic [2:0]  as;
        logic [31:0] xs;
        logic        xr;
        logic        xe;
    } vec_t;
    vec_t tbl [12];

    initial begin
        int zc;
        tbl[0]  = '{1'b1, 3'd1, 32'h05050605, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 3'd1, 32'h05050605, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 3'd0, 32'h05050605, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 3'd5, 32'h05050605, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 3'd0, 32'h05050605, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 3'd0, 32'h05050605, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 3'd0, 32'h05050606, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 3'd3, 32'h05050606, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 3'd3, 32'h05050606, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 3'd3, 32'h06050606, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 3'd0, 32'h06050606, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 3'd0, 32'h06040506, 1'b1, 1'b0};

        // long reset: no decay while held
        do_reset(30);
        chk("rst_stats", stats, 32'h05050505);
        chk("rst_alarm", alarm, 4'h0);
        chk("rst_ready", act_ready, 1'b1);
        chk("rst_err", act_err, 1'b0);

        // vector table from a fresh two-cycle reset
        do_reset(2);
        chk("rst2_stats", stats, 32'h05050505);
        for (int k = 0; k < 12; k++) begin
            act_valid = tbl[k].av;
            act_sel = tbl[k].as;
            cyc();
            chk($sformatf("tbl%0d_stats", k), stats, tbl[k].xs);
            chk($sformatf("tbl%0d_ready", k), act_ready, tbl[k].xr);
            chk($sformatf("tbl%0d_err", k), act_err, tbl[k].xe);
        end

        // idle decay to zero, single zero pulse, no underflow
        do_reset(2);
        idle(59);
        chk("decay59_stats", stats, 32'h01010101);
        chk("decay59_alarm", alarm, 4'h0);
        idle(1);
        chk("decay60_stats", stats, 32'h00000000);
        chk("decay60_alarm", alarm, 4'hF);
        chk("decay60_any", any_alarm, 1'b1);
        chk("decay60_zero_evt", zero_evt, 4'hF);
        zc = 0;
        for (int k = 0; k < 40; k++) begin
            idle(1);
            if (zero_evt != 4'h0) zc++;
        end
        chk("decay_zero_repeat", 32'(zc), 32'd0);
        chk("decay_floor_stats", stats, 32'h00000000);

        // back-to-back requests: every third accepted, saturation at 10
        do_reset(2);
        act_valid = 1'b1;
        act_sel = 3'd1;
        repeat (10) cyc();
        chk("b2b10_stat1", 32'(stats[15:8]), 32'd9);
        repeat (10) cyc();
        chk("b2b20_stat1", 32'(stats[15:8]), 32'd10);
        act_valid = 1'b0;

        // action on the decay tick of channel 0
        do_reset(2);
        idle(11);
        act_valid = 1'b1;
        act_sel = 3'd0;
        cyc();
        act_valid = 1'b0;
        chk("coll_stats", stats, 32'h04040406);
        idle(11);
        chk("coll23_stat0", 32'(stats[7:0]), 32'd6);
        idle(1);
        chk("coll24_stats", stats, 32'h03030305);

        // period 0 freezes channel 2, period 1 decays every tick
        do_reset(2);
        cfg_we = 1'b1;
        cfg_idx = 3'd2;
        cfg_period = 16'd0;
        cyc();
        idle(199);
        chk("cfg_frozen_stats", stats, 32'h00050000);
        cfg_we = 1'b1;
        cfg_idx = 3'd2;
        cfg_period = 16'd1;
        cyc();
        idle(2);
        chk("cfg203_stat2", 32'(stats[23:16]), 32'd5);
        idle(1);
        chk("cfg204_stat2", 32'(stats[23:16]), 32'd4);
        idle(4);
        chk("cfg208_stat2", 32'(stats[23:16]), 32'd3);

        // reset during cooldown and mid-decay
        do_reset(2);
        idle(9);
        act_valid = 1'b1;
        act_sel = 3'd1;
        cyc();
        act_valid = 1'b0;
        chk("mid_ready_low", act_ready, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_stats", stats, 32'h05050505);
        chk("mid_rst_ready", act_ready, 1'b1);
        chk("mid_rst_alarm", alarm, 4'h0);
        idle(11);
        chk("mid_rst11_stats", stats, 32'h05050505);
        idle(1);
        chk("mid_rst12_stats", stats, 32'h04040404);

        // random traffic against the model
        do_reset(2);
        for (int k = 0; k < 3000; k++) begin
            rst = $urandom_range(0, 299) == 0;
            act_valid = 1'($urandom_range(0, 1));
            act_sel = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            cfg_we = $urandom_range(0, 19) == 0;
            cfg_idx = 3'($urandom_range(0, 7));
            cfg_period = 16'($urandom_range(0, 4));
            cyc();
        end
        rst = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
